// File: rtl/lcd_pattern_pkg.sv
// Shared constants for the LCD test-pattern generator: mode encoding,
// RGB565 colour constants, pipeline depth and a bit-walk helper.
package lcd_pattern_pkg;

    typedef enum logic [1:0] {
        MODE_BITWALK  = 2'd0,
        MODE_GRADIENT = 2'd1,
        MODE_CHECKER  = 2'd2,
        MODE_SCROLL   = 2'd3
    } mode_t;

    localparam logic [15:0] WHITE = 16'hFFFF;
    localparam logic [15:0] BLACK = 16'h0000;

    localparam int PIPE_LAT = 2;

    // Band 0 lights bit 15, band 15 lights bit 0.
    function automatic logic [15:0] bitwalk(input logic [3:0] idx);
        return 16'h8000 >> idx;
    endfunction

endpackage

// File: rtl/lcd_pattern_gen_if.sv
// Timing-generator inputs and panel-pin outputs of the pattern generator.
// slave: the generator itself; master: whatever drives timing and watches the pins.
interface lcd_pattern_gen_if;
    logic       in_hs;
    logic       in_vs;
    logic       in_de;
    logic [9:0] in_x;
    logic [9:0] in_y;
    logic       mode_next;
    logic       lcd_hs;
    logic       lcd_vs;
    logic       lcd_de;
    logic [4:0] lcd_r;
    logic [5:0] lcd_g;
    logic [4:0] lcd_b;
    logic [1:0] mode;

    modport slave (
        input  in_hs, in_vs, in_de, in_x, in_y, mode_next,
        output lcd_hs, lcd_vs, lcd_de, lcd_r, lcd_g, lcd_b, mode
    );

    modport master (
        output in_hs, in_vs, in_de, in_x, in_y, mode_next,
        input  lcd_hs, lcd_vs, lcd_de, lcd_r, lcd_g, lcd_b, mode
    );
endinterface

// File: rtl/lcd_band_counter.sv
// Pixel/band counter: counts BAND_W pixels per band, 16 bands, saturating
// at band 15. Cleared whenever de is low so every line starts at band 0.
// The outputs are the band of the pixel currently on de/x.
module lcd_band_counter #(
    parameter int BAND_W = 30
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       de,
    output logic [3:0] band
);
    localparam int PW = (BAND_W > 1) ? $clog2(BAND_W) : 1;
    localparam logic [PW-1:0] PIX_LAST = PW'(BAND_W - 1);

    logic [PW-1:0] pix;

    // Count pixels within the band; step band at the last pixel, hold at 15.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pix  <= '0;
            band <= '0;
        end else if (!de) begin
            pix  <= '0;
            band <= '0;
        end else if (pix == PIX_LAST) begin
            pix <= '0;
            if (band != 4'd15)
                band <= band + 4'd1;
        end else begin
            pix <= pix + 1'b1;
        end
    end
endmodule

// File: rtl/lcd_pattern_gen.sv
// Two-stage registered test-pattern source for the 480-wide RGB565 LCD path.
// Stage 1 captures syncs, x/y, band index and mode; stage 2 produces colour
// and the realigned syncs. Mode and scroll offset only change at frame start.
// Optional LCD_PATTERN_CROSSHAIR_EN: white border and centre cross overlay.
module lcd_pattern_gen
    import lcd_pattern_pkg::*;
#(
    parameter int H_ACTIVE        = 480,
    parameter int V_ACTIVE        = 272,
    parameter int BAND_W          = H_ACTIVE / 16,
    parameter int CHECK_LOG2      = 5,
    parameter bit SYNC_ACTIVE_LOW = 1'b1
) (
    input  logic               rgb_clk,
    input  logic               rgb_rst,
    lcd_pattern_gen_if.slave   bus
);
    logic [3:0]  band;
    logic        hs1, vs1, de1;
    logic [9:0]  x1, y1;
    logic [3:0]  band1;
    mode_t       mode1, mode2, mode_r;
    logic        pending;
    logic [3:0]  offset;
    logic        frame_start;
    logic [3:0]  scroll_band;
    logic [15:0] pattern, colour;
    logic        hs2, vs2, de2;
    logic [15:0] rgb2;

    lcd_band_counter #(.BAND_W(BAND_W)) u_band (
        .clk  (rgb_clk),
        .rst  (rgb_rst),
        .de   (bus.in_de),
        .band (band)
    );

    // vs1 doubles as the registered copy of in_vs for edge detection.
    assign frame_start = SYNC_ACTIVE_LOW ? (vs1 & ~bus.in_vs) : (~vs1 & bus.in_vs);

    // Sticky mode request, applied along with the scroll step at frame start;
    // a request landing on the frame-start cycle waits for the next frame.
    always_ff @(posedge rgb_clk or posedge rgb_rst) begin
        if (rgb_rst) begin
            mode_r  <= MODE_BITWALK;
            pending <= 1'b0;
            offset  <= 4'd0;
        end else if (frame_start) begin
            if (pending)
                mode_r <= mode_t'(mode_r + 2'd1);
            pending <= bus.mode_next;
            offset  <= offset + 4'd1;
        end else if (bus.mode_next) begin
            pending <= 1'b1;
        end
    end

    // Stage 1: capture timing, coordinates, band and the mode in force.
    always_ff @(posedge rgb_clk or posedge rgb_rst) begin
        if (rgb_rst) begin
            hs1   <= 1'b0;
            vs1   <= 1'b0;
            de1   <= 1'b0;
            x1    <= '0;
            y1    <= '0;
            band1 <= '0;
            mode1 <= MODE_BITWALK;
        end else begin
            hs1   <= bus.in_hs;
            vs1   <= bus.in_vs;
            de1   <= bus.in_de;
            x1    <= bus.in_x;
            y1    <= bus.in_y;
            band1 <= band;
            mode1 <= mode_r;
        end
    end

    assign scroll_band = band1 + offset;

    // Pattern colour from the stage-1 values.
    always_comb begin
        pattern = BLACK;
        case (mode1)
            MODE_BITWALK:  pattern = bitwalk(band1);
            MODE_GRADIENT: pattern = {y1[8:4], x1[8:3], ~y1[8:4]};
            MODE_CHECKER:  pattern = (x1[CHECK_LOG2] ^ y1[CHECK_LOG2]) ? WHITE : BLACK;
            MODE_SCROLL:   pattern = bitwalk(scroll_band);
            default:       pattern = BLACK;
        endcase
    end

`ifdef LCD_PATTERN_CROSSHAIR_EN
    localparam logic [9:0] X_MID  = 10'(H_ACTIVE / 2);
    localparam logic [9:0] Y_MID  = 10'(V_ACTIVE / 2);
    localparam logic [9:0] X_LAST = 10'(H_ACTIVE - 1);
    localparam logic [9:0] Y_LAST = 10'(V_ACTIVE - 1);

    // Border and centre cross forced to white over any pattern.
    always_comb begin
        colour = pattern;
        if (x1 == X_MID || y1 == Y_MID || x1 == 10'd0 || x1 == X_LAST ||
            y1 == 10'd0 || y1 == Y_LAST)
            colour = WHITE;
    end
`else
    assign colour = pattern;

    // Coordinate bits and the line count the pattern alone never looks at.
    logic unused_bits;
    assign unused_bits = ^{x1[9], x1[2:0], y1[9], y1[3:0], 10'(V_ACTIVE)};
`endif

    // Stage 2: colour blanked outside de, syncs realigned to the pixel.
    always_ff @(posedge rgb_clk or posedge rgb_rst) begin
        if (rgb_rst) begin
            hs2   <= 1'b0;
            vs2   <= 1'b0;
            de2   <= 1'b0;
            rgb2  <= BLACK;
            mode2 <= MODE_BITWALK;
        end else begin
            hs2   <= hs1;
            vs2   <= vs1;
            de2   <= de1;
            rgb2  <= de1 ? colour : BLACK;
            mode2 <= mode1;
        end
    end

    assign bus.lcd_hs = hs2;
    assign bus.lcd_vs = vs2;
    assign bus.lcd_de = de2;
    assign bus.lcd_r  = rgb2[15:11];
    assign bus.lcd_g  = rgb2[10:5];
    assign bus.lcd_b  = rgb2[4:0];
    assign bus.mode   = mode2;
endmodule

// File: tb/tb_lcd_pattern_gen.sv
// Directed bench for lcd_pattern_gen: every driven cycle pushes its expected
// syncs/colour/mode to a queue, popped and compared PIPE_LAT cycles later.
module tb_lcd_pattern_gen;
    import lcd_pattern_pkg::*;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    lcd_pattern_gen_if bus ();

    lcd_pattern_gen dut (
        .rgb_clk (clk),
        .rgb_rst (rst),
        .bus     (bus)
    );

    typedef struct packed {
        logic [2:0]  sync;
        logic [17:0] pix;
    } entry_t;

    entry_t     sb[$];
    int         n_checks = 0;
    int         n_pass   = 0;
    logic [1:0] exp_mode = 2'd0;
    int         exp_off  = 0;

    function automatic logic [15:0] model(int x, int y, logic [1:0] m, int off);
        logic [9:0]  xv, yv;
        logic [15:0] c;
        int          b;
        xv = x[9:0];
        yv = y[9:0];
        b  = x / 30;
        if (b > 15) b = 15;
        case (m)
            2'd0:    c = 16'h8000 >> b;
            2'd1:    c = {yv[8:4], xv[8:3], ~yv[8:4]};
            2'd2:    c = (xv[5] ^ yv[5]) ? 16'hFFFF : 16'h0000;
            default: c = 16'h8000 >> ((b + off) % 16);
        endcase
`ifdef LCD_PATTERN_CROSSHAIR_EN
        if (x == 240 || x == 0 || x == 479 || y == 136 || y == 0 || y == 271)
            c = 16'hFFFF;
`endif
        return c;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic step();
        entry_t e;
        e.sync = {bus.in_hs, bus.in_vs, bus.in_de};
        e.pix  = {exp_mode, bus.in_de ? model(int'(bus.in_x), int'(bus.in_y), exp_mode, exp_off)
                                      : 16'h0000};
        sb.push_back(e);
        @(posedge clk);
        #1;
        if (sb.size() >= PIPE_LAT) begin
            e = sb.pop_front();
            chk("sync", {29'd0, bus.lcd_hs, bus.lcd_vs, bus.lcd_de}, {29'd0, e.sync});
            chk("pix", {14'd0, bus.mode, bus.lcd_r, bus.lcd_g, bus.lcd_b}, {14'd0, e.pix});
        end
    endtask

    task automatic line(input int y, input int n, input int pulse_at);
        bus.in_hs = 1'b0;
        step();
        step();
        bus.in_hs = 1'b1;
        step();
        bus.in_y = 10'(y);
        for (int x = 0; x < n; x++) begin
            bus.in_de     = 1'b1;
            bus.in_x      = 10'(x);
            bus.mode_next = (x == pulse_at);
            step();
        end
        bus.mode_next = 1'b0;
        bus.in_de     = 1'b0;
        step();
        step();
    endtask

    task automatic pulse();
        bus.mode_next = 1'b1;
        step();
        bus.mode_next = 1'b0;
        step();
    endtask

    // new_mode: mode the generator must show from this frame on.
    task automatic frame_start(input logic [1:0] new_mode, input bit pulse_now);
        bus.in_vs     = 1'b0;
        bus.mode_next = pulse_now;
        step();
        bus.mode_next = 1'b0;
        exp_mode      = new_mode;
        exp_off       = (exp_off + 1) % 16;
        step();
        bus.in_vs = 1'b1;
        step();
        step();
    endtask

    initial begin
        rst           = 1'b1;
        bus.in_hs     = 1'b1;
        bus.in_vs     = 1'b1;
        bus.in_de     = 1'b0;
        bus.in_x      = '0;
        bus.in_y      = '0;
        bus.mode_next = 1'b0;
        #23;
        chk("reset", {9'd0, bus.lcd_hs, bus.lcd_vs, bus.lcd_de, bus.lcd_r, bus.lcd_g,
                      bus.lcd_b, bus.mode}, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        step();
        step();

        // Mode 0 line running 8 pixels past the active width; request mid-line.
        line(0, 488, 200);
        line(1, 64, -1);
        frame_start(2'd1, 1'b0);
        line(32, 64, -1);

        // Three requests in one frame advance the mode once.
        pulse();
        pulse();
        pulse();
        line(33, 64, -1);
        frame_start(2'd2, 1'b0);
        line(0, 64, -1);
        line(100, 260, -1);

        // Request coincident with the frame-start edge lands a frame later.
        frame_start(2'd2, 1'b1);
        line(100, 40, -1);
        frame_start(2'd3, 1'b0);
        line(5, 64, -1);
        frame_start(2'd3, 1'b0);
        line(5, 340, -1);

        // Reset mid-line with a request pending.
        pulse();
        bus.in_hs = 1'b1;
        bus.in_y  = 10'd6;
        for (int x = 0; x <= 100; x++) begin
            bus.in_de = 1'b1;
            bus.in_x  = 10'(x);
            step();
        end
        rst = 1'b1;
        #1;
        chk("rst_now", {9'd0, bus.lcd_hs, bus.lcd_vs, bus.lcd_de, bus.lcd_r, bus.lcd_g,
                        bus.lcd_b, bus.mode}, 32'd0);
        sb.delete();
        bus.in_de = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_hold", {9'd0, bus.lcd_hs, bus.lcd_vs, bus.lcd_de, bus.lcd_r, bus.lcd_g,
                         bus.lcd_b, bus.mode}, 32'd0);
        rst      = 1'b0;
        exp_mode = 2'd0;
        exp_off  = 0;
        step();
        step();
        line(7, 40, -1);
        frame_start(2'd0, 1'b0);
        line(8, 64, -1);
        step();
        step();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
